// File: rtl/chipper_pkg.sv
// Shared definitions for the chipper router node:
// flit layout, port encoding and injection FSM states.
package chipper_pkg;

    localparam int FLIT_W     = 32;
    localparam int GOLDEN_BIT = 25;

    localparam int X_HI = 31;
    localparam int X_LO = 30;
    localparam int Y_HI = 29;
    localparam int Y_LO = 28;
    localparam int Z_HI = 27;
    localparam int Z_LO = 26;

    typedef enum logic [2:0] {
        PORT_N  = 3'd0,
        PORT_S  = 3'd1,
        PORT_E  = 3'd2,
        PORT_W  = 3'd3,
        PORT_U  = 3'd4,
        PORT_D  = 3'd5,
        PORT_PE = 3'd6
    } port_t;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_REQ    = 2'd1;
    localparam state_t S_STARVE = 2'd2;

    function automatic logic [FLIT_W-1:0] with_golden(
        input logic [FLIT_W-1:0] flit,
        input logic              gold
    );
        logic [FLIT_W-1:0] f;
        f = flit;
        if (gold)
            f[GOLDEN_BIT] = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/chipper_inject_ctrl_if.sv
// PE-facing and router-facing handshake bundle
// of the injection controller.
interface chipper_inject_ctrl_if
    import chipper_pkg::*;
;
    logic              pe_valid;
    logic [FLIT_W-1:0] pe_flit;
    logic              pe_ready;
    logic              inject_request;
    logic [FLIT_W-1:0] pein;
    logic              inject_grant;

    modport master (
        input  pe_valid,
        input  pe_flit,
        input  inject_grant,
        output pe_ready,
        output inject_request,
        output pein
    );

    modport slave (
        output pe_valid,
        output pe_flit,
        output inject_grant,
        input  pe_ready,
        input  inject_request,
        input  pein
    );

endinterface

// File: rtl/flit_fifo.sv
// Small circular flit buffer; callers qualify push/pop,
// full/empty are judged from count.
module flit_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/chipper_inject_ctrl.sv
// PE injection scheduler: buffers PE flits, requests the router,
// and promotes a starving head flit to golden.
module chipper_inject_ctrl
    import chipper_pkg::*;
#(
    parameter  int DEPTH        = 4,
    parameter  int STARVE_LIMIT = 8,
    parameter  int PROMOTE_EN   = 1,
    localparam int CW           = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    chipper_inject_ctrl_if.master io,
    output logic                  starved,
    output logic [CW-1:0]         occupancy,
    output logic [15:0]           inject_count
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic              push;
    logic              pop;
    logic              more;
    logic [FLIT_W-1:0] head;
    logic [FLIT_W-1:0] pein_w;
    state_t            state;
    logic [7:0]        wait_cnt;
    logic              promoted;

    flit_fifo #(
        .DEPTH (DEPTH),
        .W     (FLIT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (io.pe_flit),
        .head  (head),
        .count (occupancy)
    );

    assign io.pe_ready       = occupancy < CW'(DEPTH);
    assign io.inject_request = occupancy != '0;

    assign push = io.pe_valid && io.pe_ready;
    assign pop  = io.inject_request && io.inject_grant;
    // entries left after this edge's pop, counting a same-cycle push
    assign more = (occupancy > CW'(1)) || push;

    always_comb begin
        pein_w = '0;
        if (io.inject_request)
            pein_w = with_golden(head, promoted && (PROMOTE_EN != 0));
    end

    assign io.pein = pein_w;
    assign starved = state == S_STARVE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            promoted     <= 1'b0;
            inject_count <= '0;
        end else begin
            if (pop)
                inject_count <= inject_count + 16'd1;
            unique case (state)
                S_IDLE: begin
                    if (push)
                        state <= S_REQ;
                end
                S_REQ: begin
                    if (pop) begin
                        wait_cnt <= '0;
                        promoted <= 1'b0;
                        state    <= more ? S_REQ : S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt + 8'd1 == LIMIT) begin
                            state    <= S_STARVE;
                            promoted <= 1'b1;
                        end
                    end
                end
                S_STARVE: begin
                    if (pop) begin
                        wait_cnt <= '0;
                        promoted <= 1'b0;
                        state    <= more ? S_REQ : S_IDLE;
                    end else begin
                        wait_cnt <= LIMIT;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    wait_cnt <= '0;
                    promoted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chipper_inject_ctrl.sv
// Scoreboard bench: one promoting and one flag-only controller
// share stimulus and are checked against a queue model.
module tb_chipper_inject_ctrl;
    import chipper_pkg::*;

    localparam logic [31:0] GOLD = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pe_valid = 1'b0;
    logic [31:0] pe_flit = '0;
    logic        inject_grant = 1'b0;

    logic        starved_a;
    logic        starved_b;
    logic [2:0]  occ_a;
    logic [2:0]  occ_b;
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;

    always #5 clk = ~clk;

    chipper_inject_ctrl_if ifa ();
    chipper_inject_ctrl_if ifb ();

    assign ifa.pe_valid     = pe_valid;
    assign ifa.pe_flit      = pe_flit;
    assign ifa.inject_grant = inject_grant;
    assign ifb.pe_valid     = pe_valid;
    assign ifb.pe_flit      = pe_flit;
    assign ifb.inject_grant = inject_grant;

    chipper_inject_ctrl #(
        .DEPTH        (4),
        .STARVE_LIMIT (8),
        .PROMOTE_EN   (1)
    ) dut_a (
        .clk          (clk),
        .rst          (rst),
        .io           (ifa),
        .starved      (starved_a),
        .occupancy    (occ_a),
        .inject_count (cnt_a)
    );

    chipper_inject_ctrl #(
        .DEPTH        (4),
        .STARVE_LIMIT (8),
        .PROMOTE_EN   (0)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .io           (ifb),
        .starved      (starved_b),
        .occupancy    (occ_b),
        .inject_count (cnt_b)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] sb[$];
    int          mwait;
    bit          mstarve;
    logic [15:0] mcnt;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic model_reset();
        sb.delete();
        mwait   = 0;
        mstarve = 0;
        mcnt    = '0;
    endtask

    task automatic check_reset_outputs();
        check("rst_rdy_a", 32'(ifa.pe_ready), 32'd1);
        check("rst_req_a", 32'(ifa.inject_request), 32'd0);
        check("rst_pein_a", ifa.pein, 32'd0);
        check("rst_occ_a", 32'(occ_a), 32'd0);
        check("rst_stv_a", 32'(starved_a), 32'd0);
        check("rst_cnt_a", 32'(cnt_a), 32'd0);
        check("rst_req_b", 32'(ifb.inject_request), 32'd0);
        check("rst_occ_b", 32'(occ_b), 32'd0);
    endtask

    // one clock: drive, check against model at negedge, advance model
    task automatic cyc(
        input logic        v,
        input logic [31:0] f,
        input logic        g
    );
        int          moc;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        bit          do_pop;
        bit          do_push;
        pe_valid     = v;
        pe_flit      = f;
        inject_grant = g;
        @(negedge clk);
        moc   = sb.size();
        exp_a = '0;
        exp_b = '0;
        if (moc != 0) begin
            exp_b = sb[0];
            exp_a = mstarve ? (sb[0] | GOLD) : sb[0];
        end
        check("rdy_a", 32'(ifa.pe_ready), 32'(moc < 4));
        check("req_a", 32'(ifa.inject_request), 32'(moc != 0));
        check("occ_a", 32'(occ_a), 32'(moc));
        check("pein_a", ifa.pein, exp_a);
        check("pein_b", ifb.pein, exp_b);
        check("stv_a", 32'(starved_a), 32'(mstarve));
        check("stv_b", 32'(starved_b), 32'(mstarve));
        check("cnt_a", 32'(cnt_a), 32'(mcnt));
        check("cnt_b", 32'(cnt_b), 32'(mcnt));
        do_pop  = (moc != 0) && g;
        do_push = v && (moc < 4);
        if (do_pop) begin
            void'(sb.pop_front());
            mcnt    = mcnt + 16'd1;
            mwait   = 0;
            mstarve = 0;
        end else if (moc != 0 && !mstarve) begin
            mwait++;
            if (mwait == 8)
                mstarve = 1;
        end
        if (do_push)
            sb.push_back(f);
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;

        // single flit with grant tied high
        cyc(1'b1, 32'h4C00_0001, 1'b1);
        repeat (3) cyc(1'b0, 32'h0, 1'b1);

        // fill to full, fifth offer refused, one grant frees a slot
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 32'h1000_0010 + 32'(i), 1'b0);
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0);
        repeat (4) cyc(1'b0, 32'h0, 1'b1);

        // starvation; second flit arrives already golden
        cyc(1'b1, 32'h8400_0ABC, 1'b0);
        cyc(1'b1, 32'h3200_0055, 1'b0);
        cyc(1'b1, 32'h0000_0077, 1'b0);
        repeat (10) cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1);
        repeat (10) cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1);
        repeat (3) cyc(1'b0, 32'h0, 1'b0);
        repeat (3) cyc(1'b0, 32'h0, 1'b1);

        // steady push+pop at occupancy 2 across pointer wrap
        cyc(1'b1, 32'hA000_0000, 1'b0);
        cyc(1'b1, 32'hA000_0001, 1'b0);
        for (int i = 2; i < 12; i++)
            cyc(1'b1, 32'hA000_0000 + 32'(i), 1'b1);
        repeat (4) cyc(1'b0, 32'h0, 1'b1);

        // async reset mid-cycle with three queued and starved
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 32'h5500_0100 + 32'(i), 1'b0);
        repeat (9) cyc(1'b0, 32'h0, 1'b0);
        check("pre_rst_stv", 32'(starved_a), 32'd1);
        check("pre_rst_occ", 32'(occ_a), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        rst = 1'b0;
        repeat (3) cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b1, 32'h5000_0123, 1'b1);
        repeat (2) cyc(1'b0, 32'h0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
